// File: rtl/vx_barrier_unit_pkg.sv
// Shared GPU types for the barrier unit: barrier request/release records and
// the sizing constants derived from the warp and barrier counts.
package vx_barrier_unit_pkg;

  localparam int DEF_NUM_WARPS    = 4;
  localparam int DEF_NUM_BARRIERS = 4;

  function automatic int up(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  localparam int NW_BITS  = $clog2(DEF_NUM_WARPS);
  localparam int NW_WIDTH = up(NW_BITS);
  localparam int NB_BITS  = $clog2(DEF_NUM_BARRIERS);
  localparam int NB_WIDTH = up(NB_BITS);

  typedef struct packed {
    logic                valid;
    logic [NB_WIDTH-1:0] id;
    logic [NW_WIDTH-1:0] size_m1;
  } gpu_barrier_t;

  localparam int GPU_BARRIER_BITS = $bits(gpu_barrier_t);

  typedef struct packed {
    logic                     valid;
    logic [DEF_NUM_WARPS-1:0] wmask;
  } gpu_barrier_release_t;

  localparam int GPU_BARRIER_RELEASE_BITS = $bits(gpu_barrier_release_t);

endpackage

// File: rtl/vx_barrier_unit_if.sv
// Request/release bundle between the warp-control stage (master) and the
// barrier unit (slave).
interface vx_barrier_unit_if
  import vx_barrier_unit_pkg::*;
#(
  parameter int NUM_WARPS = DEF_NUM_WARPS
) ();

  gpu_barrier_t          barrier_in;
  logic [NW_WIDTH-1:0]   barrier_wid;
  logic                  release_valid;
  logic [NUM_WARPS-1:0]  release_wmask;
  logic [NUM_WARPS-1:0]  stalled_wmask;
  logic                  busy;

  modport master (
    output barrier_in, barrier_wid,
    input  release_valid, release_wmask, stalled_wmask, busy
  );

  modport slave (
    input  barrier_in, barrier_wid,
    output release_valid, release_wmask, stalled_wmask, busy
  );

endinterface

// File: rtl/vx_barrier_unit_entry.sv
// One barrier slot: pending-warp mask plus arrival counter. Flags completion
// combinationally so the top level can register the release pulse.
module vx_barrier_unit_entry
  import vx_barrier_unit_pkg::*;
#(
  parameter int NUM_WARPS = DEF_NUM_WARPS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_i,
  input  logic [NW_WIDTH-1:0]  wid_i,
  input  logic [NW_WIDTH-1:0]  size_m1_i,
  output logic [NUM_WARPS-1:0] mask_o,
  output logic                 complete_o,
  output logic [NUM_WARPS-1:0] rel_mask_o
);

  logic [NUM_WARPS-1:0] mask_q, mask_d;
  logic [NW_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_WARPS-1:0] wid_oh;
  logic                 dup;
  logic                 hit;

  always_comb begin
    wid_oh        = '0;
    wid_oh[wid_i] = 1'b1;
  end

  // A warp already waiting here is ignored outright; size_m1 is only ever
  // taken from the request being evaluated, never stored.
  assign dup = req_i && ((mask_q & wid_oh) != '0);
  assign hit = req_i && !dup && (cnt_q == size_m1_i);

  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (hit) begin
      mask_d = '0;
      cnt_d  = '0;
    end else if (req_i && !dup) begin
      mask_d = mask_q | wid_oh;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mask_o     = mask_q;
  assign complete_o = hit;
  assign rel_mask_o = mask_q | wid_oh;

  dup_arrival_c: cover property (@(posedge clk) disable iff (!reset_n) dup);

endmodule

// File: rtl/vx_barrier_unit.sv
// Barrier unit top: routes each request to its slot, registers the single
// release pulse and OR-reduces the pending masks into stalled/busy.
module vx_barrier_unit
  import vx_barrier_unit_pkg::*;
#(
  parameter int NUM_WARPS    = DEF_NUM_WARPS,
  parameter int NUM_BARRIERS = DEF_NUM_BARRIERS
) (
  input  logic               clk,
  input  logic               reset_n,
  vx_barrier_unit_if.slave   bar_if
);

  logic [NUM_WARPS-1:0] slot_mask [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] slot_rel  [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] slot_done;

  gpu_barrier_release_t release_q, release_d;
  logic [NUM_WARPS-1:0] stalled;

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
    logic req;
    assign req = bar_if.barrier_in.valid && (bar_if.barrier_in.id == NB_WIDTH'(b));

    vx_barrier_unit_entry #(
      .NUM_WARPS (NUM_WARPS)
    ) u_entry (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_i      (req),
      .wid_i      (bar_if.barrier_wid),
      .size_m1_i  (bar_if.barrier_in.size_m1),
      .mask_o     (slot_mask[b]),
      .complete_o (slot_done[b]),
      .rel_mask_o (slot_rel[b])
    );
  end

  // Only the addressed slot can complete, so at most one term is non-zero.
  always_comb begin
    release_d.valid = |slot_done;
    release_d.wmask = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (slot_done[b]) release_d.wmask = release_d.wmask | slot_rel[b];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      release_q <= '0;
    end else begin
      release_q <= release_d;
    end
  end

  always_comb begin
    stalled = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stalled = stalled | slot_mask[b];
    end
  end

  assign bar_if.release_valid = release_q.valid;
  assign bar_if.release_wmask = release_q.wmask;
  assign bar_if.stalled_wmask = stalled;
  assign bar_if.busy          = |stalled;

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Bench for vx_barrier_unit with 4 warps and 4 barrier slots: directed
// scenarios plus randomized traffic against a set-based reference model.
module tb_vx_barrier_unit;
  import vx_barrier_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  vx_barrier_unit_if #(.NUM_WARPS(4)) bif ();

  vx_barrier_unit #(
    .NUM_WARPS    (4),
    .NUM_BARRIERS (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bar_if  (bif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: each slot holds the set of waiting warps; arrivals so far is
  // simply the size of that set.
  bit [3:0] m_pend [4];
  bit       m_rv;
  bit [3:0] m_rm;

  function automatic bit [3:0] m_stalled();
    bit [3:0] s = '0;
    for (int b = 0; b < 4; b++) s |= m_pend[b];
    return s;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 4; b++) m_pend[b] = '0;
    m_rv = 1'b0;
    m_rm = '0;
  endtask

  // Apply one request (or idle) across one clock edge; returns 1ns after it.
  task automatic drive(input bit v, input int wid, input int id, input int sz);
    bit [3:0] oh;
    bif.barrier_in.valid   = v;
    bif.barrier_in.id      = 2'(id);
    bif.barrier_in.size_m1 = 2'(sz);
    bif.barrier_wid        = 2'(wid);
    @(posedge clk);
    m_rv = 1'b0;
    m_rm = '0;
    oh   = 4'b0001 << wid;
    if (v && reset_n && ((m_pend[id] & oh) == '0)) begin
      if ($countones(m_pend[id]) == sz) begin
        m_rv       = 1'b1;
        m_rm       = m_pend[id] | oh;
        m_pend[id] = '0;
      end else begin
        m_pend[id] |= oh;
      end
    end
    #1;
    bif.barrier_in.valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 0, 0, 0);
    drive(1, 1, 2, 1);
    n_tests++;
    if (bif.release_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rel_valid got %b exp 0", bif.release_valid); end
    n_tests++;
    if (bif.release_wmask !== 4'b0000) begin n_fail++; $display("FAIL rst_rel_wmask got %b exp 0000", bif.release_wmask); end
    n_tests++;
    if (bif.stalled_wmask !== 4'b0000) begin n_fail++; $display("FAIL rst_stalled got %b exp 0000", bif.stalled_wmask); end
    n_tests++;
    if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", bif.busy); end
    reset_n = 1'b1;
    drive(1, 2, 1, 0);
    n_tests++;
    if (bif.release_valid !== 1'b1 || bif.release_wmask !== 4'b0100) begin
      n_fail++; $display("FAIL rst_first_req got v=%b m=%b exp v=1 m=0100", bif.release_valid, bif.release_wmask);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_three_way();
    drive(1, 0, 1, 2);
    n_tests++;
    if (bif.stalled_wmask !== 4'b0001 || bif.release_valid !== 1'b0) begin
      n_fail++; $display("FAIL three_c1 got stalled=%b v=%b exp 0001 0", bif.stalled_wmask, bif.release_valid);
    end
    n_tests++;
    if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL three_busy got %b exp 1", bif.busy); end
    drive(1, 1, 1, 2);
    n_tests++;
    if (bif.stalled_wmask !== 4'b0011 || bif.release_valid !== 1'b0) begin
      n_fail++; $display("FAIL three_c2 got stalled=%b v=%b exp 0011 0", bif.stalled_wmask, bif.release_valid);
    end
    drive(1, 2, 1, 2);
    n_tests++;
    if (bif.release_valid !== 1'b1 || bif.release_wmask !== 4'b0111) begin
      n_fail++; $display("FAIL three_release got v=%b m=%b exp 1 0111", bif.release_valid, bif.release_wmask);
    end
    n_tests++;
    if (bif.stalled_wmask !== 4'b0000 || bif.busy !== 1'b0) begin
      n_fail++; $display("FAIL three_c3_stalled got %b busy=%b exp 0000 0", bif.stalled_wmask, bif.busy);
    end
    drive(0, 0, 0, 0);
    n_tests++;
    if (bif.release_valid !== 1'b0) begin n_fail++; $display("FAIL three_pulse got %b exp 0", bif.release_valid); end
  endtask

  task automatic test_immediate();
    drive(1, 3, 0, 0);
    n_tests++;
    if (bif.release_valid !== 1'b1 || bif.release_wmask !== 4'b1000) begin
      n_fail++; $display("FAIL imm_release got v=%b m=%b exp 1 1000", bif.release_valid, bif.release_wmask);
    end
    n_tests++;
    if (bif.busy !== 1'b0 || bif.stalled_wmask !== 4'b0000) begin
      n_fail++; $display("FAIL imm_busy got busy=%b stalled=%b exp 0 0000", bif.busy, bif.stalled_wmask);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_duplicate();
    drive(1, 1, 2, 1);
    n_tests++;
    if (bif.stalled_wmask !== 4'b0010) begin n_fail++; $display("FAIL dup_first got %b exp 0010", bif.stalled_wmask); end
    drive(1, 1, 2, 1);
    n_tests++;
    if (bif.release_valid !== 1'b0 || bif.stalled_wmask !== 4'b0010) begin
      n_fail++; $display("FAIL dup_ignored got v=%b stalled=%b exp 0 0010", bif.release_valid, bif.stalled_wmask);
    end
    drive(1, 0, 2, 1);
    n_tests++;
    if (bif.release_valid !== 1'b1 || bif.release_wmask !== 4'b0011) begin
      n_fail++; $display("FAIL dup_release got v=%b m=%b exp 1 0011", bif.release_valid, bif.release_wmask);
    end
    drive(0, 0, 0, 0);
    n_tests++;
    if (bif.release_valid !== 1'b0 || bif.busy !== 1'b0) begin
      n_fail++; $display("FAIL dup_single got v=%b busy=%b exp 0 0", bif.release_valid, bif.busy);
    end
  endtask

  task automatic test_interleaved();
    drive(1, 0, 0, 1);
    drive(1, 1, 3, 1);
    n_tests++;
    if (bif.stalled_wmask !== 4'b0011) begin n_fail++; $display("FAIL intl_c2 got %b exp 0011", bif.stalled_wmask); end
    drive(1, 2, 0, 1);
    n_tests++;
    if (bif.release_valid !== 1'b1 || bif.release_wmask !== 4'b0101 || bif.stalled_wmask !== 4'b0010) begin
      n_fail++; $display("FAIL intl_c3 got v=%b m=%b stalled=%b exp 1 0101 0010",
                         bif.release_valid, bif.release_wmask, bif.stalled_wmask);
    end
    drive(1, 3, 3, 1);
    n_tests++;
    if (bif.release_valid !== 1'b1 || bif.release_wmask !== 4'b1010 || bif.stalled_wmask !== 4'b0000) begin
      n_fail++; $display("FAIL intl_c4 got v=%b m=%b stalled=%b exp 1 1010 0000",
                         bif.release_valid, bif.release_wmask, bif.stalled_wmask);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 3);
    drive(1, 1, 1, 3);
    n_tests++;
    if (bif.stalled_wmask !== 4'b0011 || bif.busy !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pending got %b busy=%b exp 0011 1", bif.stalled_wmask, bif.busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bif.stalled_wmask !== 4'b0000 || bif.busy !== 1'b0 || bif.release_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async got stalled=%b busy=%b v=%b exp 0000 0 0",
                         bif.stalled_wmask, bif.busy, bif.release_valid);
    end
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2 + (i % 2), 1, 3);
      n_tests++;
      if (bif.release_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_release cyc %0d got %b exp 0", i, bif.release_valid); end
    end
    n_tests++;
    if (bif.stalled_wmask !== 4'b1100) begin n_fail++; $display("FAIL rmid_fresh got %b exp 1100", bif.stalled_wmask); end
    reset_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    bit v;
    int wid, id, sz;
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      wid = $urandom_range(0, 3);
      id  = $urandom_range(0, 3);
      sz  = $urandom_range(0, 3);
      drive(v, wid, id, sz);
      n_tests++;
      if (bif.release_valid !== m_rv) begin
        n_fail++; $display("FAIL rand_rel_valid cyc %0d got %b exp %b", c, bif.release_valid, m_rv);
      end
      if (m_rv) begin
        n_tests++;
        if (bif.release_wmask !== m_rm) begin
          n_fail++; $display("FAIL rand_rel_wmask cyc %0d got %b exp %b", c, bif.release_wmask, m_rm);
        end
      end
      n_tests++;
      if (bif.stalled_wmask !== m_stalled() || bif.busy !== (m_stalled() != '0)) begin
        n_fail++; $display("FAIL rand_stalled cyc %0d got %b busy=%b exp %b", c, bif.stalled_wmask, bif.busy, m_stalled());
      end
    end
  endtask

  initial begin
    bif.barrier_in  = '0;
    bif.barrier_wid = '0;
    model_clear();
    test_reset();
    test_three_way();
    test_immediate();
    test_duplicate();
    test_interleaved();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
